// File: rtl/ALU_sel.sv
// ALU operation select codes shared by the multicycle control unit and the ALU.
package ALU_sel;

    localparam logic [4:0] SEL_ADD  = 5'd0;
    localparam logic [4:0] SEL_SUB  = 5'd1;
    localparam logic [4:0] SEL_SLL  = 5'd2;
    localparam logic [4:0] SEL_SLT  = 5'd3;
    localparam logic [4:0] SEL_SLTU = 5'd4;
    localparam logic [4:0] SEL_XOR  = 5'd5;
    localparam logic [4:0] SEL_SRL  = 5'd6;
    localparam logic [4:0] SEL_SRA  = 5'd7;
    localparam logic [4:0] SEL_OR   = 5'd8;
    localparam logic [4:0] SEL_AND  = 5'd9;
    localparam logic [4:0] SEL_MUL  = 5'd10;

endpackage

// File: rtl/riscv_ctrl_pkg.sv
// Shared types for the RV32I multicycle control unit: FSM states, opcodes,
// datapath mux encodings and the bundle of control outputs.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB,
        S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC, S_ILLEGAL
    } state_t;

    typedef enum logic [1:0] { CLS_R, CLS_I, CLS_BRANCH } op_class_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [1:0] SRC_A_PC    = 2'd0;
    localparam logic [1:0] SRC_A_OLDPC = 2'd1;
    localparam logic [1:0] SRC_A_RS1   = 2'd2;
    localparam logic [1:0] SRC_A_ZERO  = 2'd3;

    localparam logic [1:0] SRC_B_RS2   = 2'd0;
    localparam logic [1:0] SRC_B_IMM   = 2'd1;
    localparam logic [1:0] SRC_B_FOUR  = 2'd2;

    localparam logic       PC_SRC_ALU    = 1'b0;
    localparam logic       PC_SRC_ALUOUT = 1'b1;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    typedef struct packed {
        logic [4:0] alu_sel;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic       pc_write;
        logic       pc_src;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{alu_sel: ALU_sel::SEL_ADD, default: '0};

endpackage

// File: rtl/alu_op_decode.sv
// Combinational funct3/funct7 decode to an ALU select code plus a legality flag.
// Macro RV32M_MUL_EN enables decoding of the R-type MUL instruction.
module alu_op_decode
    import riscv_ctrl_pkg::*;
    import ALU_sel::*;
(
    input  op_class_t  op_class,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [4:0] alu_sel,
    output logic       legal
);

    always_comb begin
        alu_sel = SEL_ADD;
        legal   = 1'b1;
        if (op_class == CLS_BRANCH) begin
            case (funct3)
                3'b000, 3'b001: alu_sel = SEL_SUB;
                3'b100, 3'b101: alu_sel = SEL_SLT;
                3'b110, 3'b111: alu_sel = SEL_SLTU;
                default:        legal   = 1'b0;
            endcase
        end else begin
            case (funct3)
                3'b000:  alu_sel = SEL_ADD;
                3'b001:  alu_sel = SEL_SLL;
                3'b010:  alu_sel = SEL_SLT;
                3'b011:  alu_sel = SEL_SLTU;
                3'b100:  alu_sel = SEL_XOR;
                3'b101:  alu_sel = SEL_SRL;
                3'b110:  alu_sel = SEL_OR;
                default: alu_sel = SEL_AND;
            endcase
            if (op_class == CLS_R) begin
                if (funct7 == F7_BASE) begin
                    legal = 1'b1;
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == 3'b000)      alu_sel = SEL_SUB;
                    else if (funct3 == 3'b101) alu_sel = SEL_SRA;
                    else                       legal   = 1'b0;
                end else if (funct7 == F7_MULDIV) begin
`ifdef RV32M_MUL_EN
                    if (funct3 == 3'b000) alu_sel = SEL_MUL;
                    else                  legal   = 1'b0;
`else
                    legal = 1'b0;
`endif
                end else begin
                    legal = 1'b0;
                end
            end else begin
                // Immediate forms: funct7 only carries meaning for the shifts.
                if (funct3 == 3'b101 && funct7[5]) alu_sel = SEL_SRA;
                if (funct3 == 3'b001 && funct7 != F7_BASE) legal = 1'b0;
            end
        end
    end

endmodule

// File: rtl/riscv_mc_control.sv
// Multicycle RV32I control unit: Moore FSM producing datapath strobes and ALU select.
// Optional macro RV32M_MUL_EN enables R-type MUL decode.
module riscv_mc_control
    import riscv_ctrl_pkg::*;
    import ALU_sel::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    output logic [4:0] alu_sel,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       pc_write,
    output logic       pc_src,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       illegal
);

    state_t    state, next_state;
    ctrl_t     ctrl_q, ctrl;
    op_class_t dec_class;
    logic [4:0] dec_sel;
    logic      dec_legal;
    logic      legal_q, is_load_q, br_inv_q;
    logic      branch_taken;

    always_comb begin
        dec_class = CLS_I;
        if (opcode == OP_R)           dec_class = CLS_R;
        else if (opcode == OP_BRANCH) dec_class = CLS_BRANCH;
    end

    alu_op_decode u_alu_op_decode (
        .op_class (dec_class),
        .funct3   (funct3),
        .funct7   (funct7),
        .alu_sel  (dec_sel),
        .legal    (dec_legal)
    );

    function automatic ctrl_t state_ctrl(input state_t s, input logic [4:0] sel);
        ctrl_t c;
        c = CTRL_IDLE;
        case (s)
            S_FETCH: begin
                c.mem_read = 1'b1; c.ir_write = 1'b1; c.pc_write = 1'b1;
                c.src_a = SRC_A_PC; c.src_b = SRC_B_FOUR;
            end
            S_DECODE:   begin c.src_a = SRC_A_OLDPC; c.src_b = SRC_B_IMM; end
            S_EXEC_R:   begin c.src_a = SRC_A_RS1; c.src_b = SRC_B_RS2; c.alu_sel = sel; end
            S_EXEC_I:   begin c.src_a = SRC_A_RS1; c.src_b = SRC_B_IMM; c.alu_sel = sel; end
            S_ALU_WB:   begin c.reg_write = 1'b1; c.wb_sel = WB_ALUOUT; end
            S_MEM_ADDR: begin c.src_a = SRC_A_RS1; c.src_b = SRC_B_IMM; end
            S_MEM_RD:   begin c.mem_read = 1'b1; c.iord = 1'b1; end
            S_MEM_WB:   begin c.reg_write = 1'b1; c.wb_sel = WB_MDR; end
            S_MEM_WR:   begin c.mem_write = 1'b1; c.iord = 1'b1; end
            S_BRANCH: begin
                c.src_a = SRC_A_RS1; c.src_b = SRC_B_RS2; c.alu_sel = sel;
                c.pc_src = PC_SRC_ALUOUT;
            end
            S_JAL: begin
                c.reg_write = 1'b1; c.wb_sel = WB_PC;
                c.pc_write = 1'b1; c.pc_src = PC_SRC_ALUOUT;
            end
            S_JALR: begin
                c.src_a = SRC_A_RS1; c.src_b = SRC_B_IMM;
                c.pc_write = 1'b1; c.pc_src = PC_SRC_ALU;
                c.reg_write = 1'b1; c.wb_sel = WB_PC;
            end
            S_LUI:      begin c.src_a = SRC_A_ZERO;  c.src_b = SRC_B_IMM; end
            S_AUIPC:    begin c.src_a = SRC_A_OLDPC; c.src_b = SRC_B_IMM; end
            S_ILLEGAL:  c.illegal = 1'b1;
            default:    c = CTRL_IDLE;
        endcase
        return c;
    endfunction

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH: next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:               next_state = S_EXEC_R;
                    OP_I:               next_state = S_EXEC_I;
                    OP_LOAD, OP_STORE:  next_state = S_MEM_ADDR;
                    OP_BRANCH:          next_state = S_BRANCH;
                    OP_JAL:             next_state = S_JAL;
                    OP_JALR:            next_state = S_JALR;
                    OP_LUI:             next_state = S_LUI;
                    OP_AUIPC:           next_state = S_AUIPC;
                    default:            next_state = S_ILLEGAL;
                endcase
            end
            S_EXEC_R, S_EXEC_I:  next_state = legal_q ? S_ALU_WB : S_ILLEGAL;
            S_MEM_ADDR:          next_state = is_load_q ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:            next_state = S_MEM_WB;
            S_BRANCH:            next_state = legal_q ? S_FETCH : S_ILLEGAL;
            S_LUI, S_AUIPC:      next_state = S_ALU_WB;
            default:             next_state = S_FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_FETCH;
            ctrl_q    <= state_ctrl(S_FETCH, SEL_ADD);
            legal_q   <= 1'b0;
            is_load_q <= 1'b0;
            br_inv_q  <= 1'b0;
        end else begin
            state  <= next_state;
            ctrl_q <= state_ctrl(next_state, dec_sel);
            if (state == S_DECODE) begin
                legal_q   <= dec_legal;
                is_load_q <= (opcode == OP_LOAD);
                // BNE/BLT/BLTU are taken when the ALU result is non-zero.
                br_inv_q  <= funct3[0] ^ funct3[2];
            end
        end
    end

    assign branch_taken = (state == S_BRANCH) && legal_q && (zero ^ br_inv_q);

    // NOTE: the output register resets to the FETCH pattern so FETCH is live on
    // the first cycle after release; rst masks it so strobes drop the moment
    // reset asserts rather than at the next clock.
    always_comb begin
        ctrl = rst ? CTRL_IDLE : ctrl_q;
        ctrl.pc_write = ctrl.pc_write | branch_taken;
    end

    assign alu_sel   = ctrl.alu_sel;
    assign alu_src_a = ctrl.src_a;
    assign alu_src_b = ctrl.src_b;
    assign pc_write  = ctrl.pc_write;
    assign pc_src    = ctrl.pc_src;
    assign ir_write  = ctrl.ir_write;
    assign iord      = ctrl.iord;
    assign mem_read  = ctrl.mem_read;
    assign mem_write = ctrl.mem_write;
    assign reg_write = ctrl.reg_write;
    assign wb_sel    = ctrl.wb_sel;
    assign illegal   = ctrl.illegal;

endmodule
